data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning the word-address width of the internal array (2^ADDR_BITS x 16-bit words).
REQ-002 SHALL have parameter WB_DEPTH, default 2, meaning the number of posted-write buffer entries.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_r_en  in  1  read request from execute, one cycle per request.
REQ-006 mem_r_addr  in  16  read word address.
REQ-007 mem_r_data  out  16  read data, registered.
REQ-008 mem_r_valid  out  1  one-cycle pulse qualifying mem_r_data.
REQ-009 mem_w_en  in  1  write request from execute.
REQ-010 mem_w_addr  in  16  write word address.
REQ-011 mem_w_data  in  16  write data.
REQ-012 mem_stall  out  1  write buffer full; a write presented while high is not accepted.
REQ-013 mem_fault  out  1  one-cycle pulse: the prior-cycle request had an out-of-range address.

Function
REQ-014 SHALL act as the responder to execute's load/store port: reads return data; writes are posted into a FIFO buffer and drained to a single-port array.
REQ-015 SHALL treat an address as out of range when any of bits [15:ADDR_BITS] is nonzero.
REQ-016 SHALL use read latency 1: for mem_r_en high at edge N, mem_r_valid=1 and mem_r_data are valid after edge N+1, for that cycle only.
REQ-017 SHALL resolve read data by priority: newest matching buffer entry, then older buffer entry, then array contents.
REQ-018 SHALL NOT forward a write accepted in the same cycle as a read to the same address; the read returns the prior value.
REQ-019 SHALL accept a write (enqueue at tail) when mem_w_en=1 and mem_stall=0 at the edge, independent of any same-cycle read.
REQ-020 SHALL ignore a write presented while mem_stall=1, with no state change; the requester holds the request until stall drops.
REQ-021 SHALL drain the oldest buffer entry to the array in any cycle where the buffer is non-empty and mem_r_en=0 or the read is faulting. Reads take priority over draining.
REQ-022 SHALL allow enqueue and drain in the same cycle; the count stays unchanged in that case.
REQ-023 SHALL drive mem_stall = (count == WB_DEPTH), derived from registered count only.
REQ-024 SHALL, for an out-of-range read, return mem_r_data=0 with mem_r_valid=1 and mem_fault=1 in the following cycle.
REQ-025 SHALL drop an out-of-range write without enqueueing it, pulse mem_fault the following cycle, and keep mem_stall unaffected.
REQ-026 SHALL pulse mem_fault for one cycle when both a read fault and a write fault occur in the same cycle.
REQ-027 SHALL keep the buffer count within 0..WB_DEPTH, with head/tail pointers wrapping modulo WB_DEPTH.

Reset
REQ-028 SHALL, on reset high at an edge, set mem_r_data=0, mem_r_valid=0, mem_fault=0, count=0, head=tail=0, and mem_stall=0.
REQ-029 SHALL discard pending buffered writes on reset, including a reset asserted mid-drain; array contents are not cleared.
REQ-030 SHALL ignore requests in a cycle where reset is high.

Verification
REQ-031 Write 0x0010<=0xBEEF, next cycle read 0x0010 -> one cycle later mem_r_valid=1, mem_r_data=0xBEEF (forwarded from buffer).
REQ-032 Same-cycle write 0x0020<=0x1234 and read 0x0020 (prior 0x0000) -> read returns 0x0000; a read two cycles later returns 0x1234.
REQ-033 Reads every cycle plus writes 0x0001<=0xAAAA, 0x0002<=0xBBBB -> mem_stall=1; a third write 0x0003 is held and not accepted; stop reads -> two drains, stall drops, write accepted, later reads return all three values.
REQ-034 Read 0x0100 with ADDR_BITS=8 -> next cycle mem_r_valid=1, mem_r_data=0x0000, mem_fault=1; write 0x8000<=0xFFFF -> mem_fault=1, count unchanged.
REQ-035 Two writes to 0x0005 (0x1111 then 0x2222) buffered, read 0x0005 -> 0x2222 (newest entry wins).
REQ-036 Buffer full, reset asserted one cycle -> mem_stall=0, mem_r_valid=0, mem_fault=0; reads of the buffered addresses return the pre-write array values.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store responder with posted-write FIFO, read forwarding and a single-port word array
module data_mem_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int WB_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic [15:0] mem_r_addr,
  output logic [15:0] mem_r_data,
  output logic        mem_r_valid,
  input  logic        mem_w_en,
  input  logic [15:0] mem_w_addr,
  input  logic [15:0] mem_w_data,
  output logic        mem_stall,
  output logic        mem_fault
);
  localparam int PW = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);
  logic [15:0] mem [2**ADDR_BITS];
  logic [15:0] wb_addr [WB_DEPTH];
  logic [15:0] wb_data [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic r_oob, w_oob, r_fault, w_fault, enq, drain;
  logic [15:0] fwd_data;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign r_oob     = |mem_r_addr[15:ADDR_BITS];
  assign w_oob     = |mem_w_addr[15:ADDR_BITS];
  assign mem_stall = count == CW'(WB_DEPTH);
  assign r_fault   = mem_r_en && r_oob;
  assign w_fault   = mem_w_en && !mem_stall && w_oob;
  assign enq       = mem_w_en && !mem_stall && !w_oob;
  assign drain     = count != '0 && (!mem_r_en || r_oob);
  // read resolution: walk buffer oldest to newest so the newest match overrides the array value
  always_comb begin
    logic [PW:0] s;
    logic [PW-1:0] k;
    fwd_data = mem[mem_r_addr[ADDR_BITS-1:0]];
    for (int i = 0; i < WB_DEPTH; i++) begin
      s = {1'b0, head} + (PW+1)'(i);
      k = s >= (PW+1)'(WB_DEPTH) ? PW'(s - (PW+1)'(WB_DEPTH)) : PW'(s);
      if (i < int'(count) && wb_addr[k] == mem_r_addr) fwd_data = wb_data[k];
    end
  end
  // control state: pointers, count and registered read/fault outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      mem_r_data  <= '0;
      mem_r_valid <= 1'b0;
      mem_fault   <= 1'b0;
    end else begin
      mem_r_valid <= mem_r_en;
      if (mem_r_en) mem_r_data <= r_oob ? '0 : fwd_data;
      mem_fault <= r_fault || w_fault;
      if (enq) tail <= inc(tail);
      if (drain) head <= inc(head);
      count <= count + CW'(enq) - CW'(drain);
    end
  end
  // storage: buffer entries and array are not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      wb_addr[tail] <= mem_w_addr;
      wb_data[tail] <= mem_w_data;
    end
    if (!reset && drain) mem[wb_addr[head][ADDR_BITS-1:0]] <= wb_data[head];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of forwarding, stall, fault and reset behaviour
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_r_en = 1'b0;
  logic [15:0] mem_r_addr = '0;
  logic [15:0] mem_r_data;
  logic        mem_r_valid;
  logic        mem_w_en = 1'b0;
  logic [15:0] mem_w_addr = '0;
  logic [15:0] mem_w_data = '0;
  logic        mem_stall;
  logic        mem_fault;
  int n_tests = 0;
  int n_fail = 0;
  data_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_stall(mem_stall), .mem_fault(mem_fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic re, input logic [15:0] ra, input logic we, input logic [15:0] wa, input logic [15:0] wd);
    mem_r_en = re; mem_r_addr = ra; mem_w_en = we; mem_w_addr = wa; mem_w_data = wd;
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask
  initial begin
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_valid", {15'b0, mem_r_valid}, 16'h0);
    chk("rst_data", mem_r_data, 16'h0);
    chk("rst_fault", {15'b0, mem_fault}, 16'h0);
    chk("rst_stall", {15'b0, mem_stall}, 16'h0);
    step(1'b0, 0, 1'b1, 16'h0020, 16'h0000);
    step(1'b0, 0, 1'b1, 16'h0001, 16'h0000);
    step(1'b0, 0, 1'b1, 16'h0002, 16'h0000);
    step(1'b0, 0, 1'b1, 16'h0003, 16'h0000);
    step(1'b0, 0, 1'b1, 16'h0005, 16'h0000);
    step(1'b0, 0, 1'b1, 16'h0010, 16'h0000);
    idle(3);
    step(1'b0, 0, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 16'h0010, 1'b0, 0, 0);
    chk("fwd_valid", {15'b0, mem_r_valid}, 16'h1);
    chk("fwd_data", mem_r_data, 16'hBEEF);
    idle(1);
    chk("valid_pulse", {15'b0, mem_r_valid}, 16'h0);
    idle(1);
    step(1'b1, 16'h0020, 1'b1, 16'h0020, 16'h1234);
    chk("same_cyc_prior", mem_r_data, 16'h0000);
    idle(1);
    step(1'b1, 16'h0020, 1'b0, 0, 0);
    chk("same_cyc_later", mem_r_data, 16'h1234);
    idle(2);
    step(1'b1, 16'h0000, 1'b1, 16'h0001, 16'hAAAA);
    chk("stall_one", {15'b0, mem_stall}, 16'h0);
    step(1'b1, 16'h0000, 1'b1, 16'h0002, 16'hBBBB);
    chk("stall_full", {15'b0, mem_stall}, 16'h1);
    step(1'b1, 16'h0000, 1'b1, 16'h0003, 16'hCCCC);
    chk("stall_hold", {15'b0, mem_stall}, 16'h1);
    step(1'b0, 0, 1'b1, 16'h0003, 16'hCCCC);
    chk("stall_drop", {15'b0, mem_stall}, 16'h0);
    step(1'b0, 0, 1'b1, 16'h0003, 16'hCCCC);
    chk("stall_enq_drain", {15'b0, mem_stall}, 16'h0);
    idle(3);
    step(1'b1, 16'h0001, 1'b0, 0, 0);
    chk("rd_1", mem_r_data, 16'hAAAA);
    step(1'b1, 16'h0002, 1'b0, 0, 0);
    chk("rd_2", mem_r_data, 16'hBBBB);
    step(1'b1, 16'h0003, 1'b0, 0, 0);
    chk("rd_3", mem_r_data, 16'hCCCC);
    idle(1);
    step(1'b1, 16'h0100, 1'b0, 0, 0);
    chk("rfault_valid", {15'b0, mem_r_valid}, 16'h1);
    chk("rfault_data", mem_r_data, 16'h0000);
    chk("rfault_flag", {15'b0, mem_fault}, 16'h1);
    idle(1);
    chk("fault_pulse", {15'b0, mem_fault}, 16'h0);
    step(1'b0, 0, 1'b1, 16'h8000, 16'hFFFF);
    chk("wfault_flag", {15'b0, mem_fault}, 16'h1);
    chk("wfault_stall", {15'b0, mem_stall}, 16'h0);
    step(1'b1, 16'h0000, 1'b1, 16'h0007, 16'h7777);
    chk("wfault_cnt", {15'b0, mem_stall}, 16'h0);
    step(1'b1, 16'h0000, 1'b1, 16'h0006, 16'h6666);
    chk("wfault_cnt_full", {15'b0, mem_stall}, 16'h1);
    idle(3);
    step(1'b1, 16'h0200, 1'b1, 16'h0400, 16'h1);
    chk("dual_fault", {15'b0, mem_fault}, 16'h1);
    idle(1);
    chk("dual_fault_end", {15'b0, mem_fault}, 16'h0);
    step(1'b1, 16'h0001, 1'b1, 16'h0005, 16'h1111);
    step(1'b1, 16'h0001, 1'b1, 16'h0005, 16'h2222);
    step(1'b1, 16'h0005, 1'b0, 0, 0);
    chk("newest_wins", mem_r_data, 16'h2222);
    idle(3);
    step(1'b1, 16'h0020, 1'b1, 16'h0001, 16'h5555);
    step(1'b1, 16'h0020, 1'b1, 16'h0002, 16'h6666);
    chk("pre_rst_full", {15'b0, mem_stall}, 16'h1);
    reset = 1'b1;
    step(1'b1, 16'h0001, 1'b1, 16'h0003, 16'h9999);
    reset = 1'b0;
    chk("rst2_stall", {15'b0, mem_stall}, 16'h0);
    chk("rst2_valid", {15'b0, mem_r_valid}, 16'h0);
    chk("rst2_fault", {15'b0, mem_fault}, 16'h0);
    step(1'b1, 16'h0001, 1'b0, 0, 0);
    chk("rst2_rd1", mem_r_data, 16'hAAAA);
    step(1'b1, 16'h0002, 1'b0, 0, 0);
    chk("rst2_rd2", mem_r_data, 16'hBBBB);
    step(1'b1, 16'h0003, 1'b0, 0, 0);
    chk("rst2_rd3", mem_r_data, 16'hCCCC);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
